seq_divider: RTL and testbench

//   Multi-cycle unsigned restoring divider: dividend / divisor -> quotient, remainder.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider family: FSM state encoding and
// default operand widths reused by divider/multiplier variants.
package seq_divider_pkg;

  localparam int DEF_DVD_W = 4;
  localparam int DEF_DVS_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the
// divisor when it fits, and report the resulting quotient bit.
import seq_divider_pkg::*;

module div_step #(
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic [DVS_W:0]   prem,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W:0]   prem_next,
  output logic             qbit
);

  logic [DVS_W:0] shifted;
  logic [DVS_W:0] diff;

  // The partial remainder is always below the divisor, so one extra bit keeps
  // the shifted value and the compare free of overflow.
  always_comb begin
    shifted   = (prem << 1) | {{DVS_W{1'b0}}, bit_in};
    diff      = shifted - {1'b0, divisor};
    qbit      = (shifted >= {1'b0, divisor});
    prem_next = qbit ? diff : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB first.
// Define SEQ_DIV_DBZ_EN to add the dbz port and the one-cycle divide-by-zero path.
import seq_divider_pkg::*;

module seq_divider #(
  parameter int DVD_W = DEF_DVD_W,
  parameter int DVS_W = DEF_DVS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
`ifdef SEQ_DIV_DBZ_EN
  ,
  output logic             dbz
`endif
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DVD_W - 1);

  div_state_e       state_q, state_d;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [DVS_W:0]   prem_q, prem_next;
  logic [DVD_W-1:0] quo_q, quo_next;
  logic [CNT_W-1:0] cnt_q;
  logic             qbit;
  logic             load;
  logic             finish;

  div_step #(.DVS_W(DVS_W)) u_step (
    .prem      (prem_q),
    .bit_in    (dvd_q[DVD_W-1]),
    .divisor   (dvs_q),
    .prem_next (prem_next),
    .qbit      (qbit)
  );

  assign quo_next = (quo_q << 1) | DVD_W'(qbit);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
`ifdef SEQ_DIV_DBZ_EN
          if (divisor == '0) state_d = DONE;
`endif
        end
      end
      RUN: begin
        if (cnt_q == LAST_STEP) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (load) begin
        dvd_q  <= dividend;
        dvs_q  <= divisor;
        prem_q <= '0;
        quo_q  <= '0;
        cnt_q  <= '0;
      end else if (state_q == RUN) begin
        dvd_q  <= dvd_q << 1;
        prem_q <= prem_next;
        quo_q  <= quo_next;
        cnt_q  <= cnt_q + CNT_W'(1);
      end
      // A zero divisor runs the full iteration but reports a forced result.
      if (finish) begin
        quotient  <= (dvs_q == '0) ? '1 : quo_next;
        remainder <= (dvs_q == '0) ? '0 : prem_next[DVS_W-1:0];
      end
`ifdef SEQ_DIV_DBZ_EN
      if (load && divisor == '0) begin
        quotient  <= '1;
        remainder <= '0;
      end
`endif
    end
  end

`ifdef SEQ_DIV_DBZ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         dbz <= 1'b0;
    else if (load && divisor == '0)  dbz <= 1'b1;
    else if (finish)                 dbz <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, protocol stress, an
// exhaustive back-to-back sweep and random operations against an arithmetic model.
module tb_seq_divider;

  localparam int DVD_W = 4;
  localparam int DVS_W = 2;
`ifdef SEQ_DIV_DBZ_EN
  localparam bit DBZ_EN = 1'b1;
`else
  localparam bit DBZ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [DVD_W-1:0] dividend = '0;
  logic [DVS_W-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
`ifdef SEQ_DIV_DBZ_EN
  logic             dbz;
`endif

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  seq_divider #(.DVD_W(DVD_W), .DVS_W(DVS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQ_DIV_DBZ_EN
    ,
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain division, with the fixed result for a zero divisor.
  function automatic void golden(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << DVD_W) - 1;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Cycles from the accepting edge to the first negedge showing done.
  function automatic int latency(input int b);
    return (DBZ_EN && b == 0) ? 1 : DVD_W + 1;
  endfunction

  task automatic run_op(input int a, input int b, input bit disturb);
    int k, busy_n, eq, er;
    bit seen, fast;
    golden(a, b, eq, er);
    fast = DBZ_EN && (b == 0);
    @(posedge clk); #1;
    dividend = DVD_W'(a);
    divisor  = DVS_W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) busy_n++;
        if (disturb && !fast) begin
          if (k == 2) begin
            start    = 1'b1;
            dividend = DVD_W'($urandom);
            divisor  = DVS_W'($urandom);
          end else start = 1'b0;
        end
      end
    end
    check($sformatf("done_seen %0d/%0d", a, b), 32'(seen), 32'd1);
    check($sformatf("latency %0d/%0d", a, b), 32'(k), 32'(latency(b)));
    check($sformatf("busy_cycles %0d/%0d", a, b), 32'(busy_n), fast ? 32'd0 : 32'(DVD_W));
    check($sformatf("quotient %0d/%0d", a, b), 32'(quotient), 32'(eq));
    check($sformatf("remainder %0d/%0d", a, b), 32'(remainder), 32'(er));
`ifdef SEQ_DIV_DBZ_EN
    check($sformatf("dbz %0d/%0d", a, b), 32'(dbz), 32'(b == 0));
`endif
    @(negedge clk);
    check($sformatf("done_pulse %0d/%0d", a, b), 32'(done), 32'd0);
    check($sformatf("q_hold %0d/%0d", a, b), 32'(quotient), 32'(eq));
    check($sformatf("r_hold %0d/%0d", a, b), 32'(remainder), 32'(er));
  endtask

  initial begin
    int c0, eq, er, k, a, b;
    bit seen;

    // Reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
`ifdef SEQ_DIV_DBZ_EN
    check("rst_dbz", 32'(dbz), 32'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op(15, 2, 1'b0);
    run_op(9, 3, 1'b0);
    run_op(2, 3, 1'b0);
    run_op(7, 0, 1'b0);
    run_op(13, 3, 1'b0);

    // start pulsed and operands changed during RUN
    run_op(15, 2, 1'b1);
    run_op(11, 2, 1'b1);

    // Reset mid-RUN discards the operation
    @(posedge clk); #1;
    dividend = 4'd14; divisor = 2'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    c0 = done_cnt;
    check("midrun_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_quotient", 32'(quotient), 32'd0);
    check("midrun_rst_remainder", 32'(remainder), 32'd0);
`ifdef SEQ_DIV_DBZ_EN
    check("midrun_rst_dbz", 32'(dbz), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("midrun_no_done", 32'(done_cnt - c0), 32'd0);
    check("midrun_q_after", 32'(quotient), 32'd0);
    run_op(9, 3, 1'b0);

    // Exhaustive sweep with start held high, operands swapped in the DONE cycle
    @(posedge clk); #1;
    c0 = done_cnt;
    dividend = '0; divisor = '0; start = 1'b1;
    for (int i = 0; i < (1 << (DVD_W + DVS_W)); i++) begin
      a = i >> DVS_W;
      b = i & ((1 << DVS_W) - 1);
      golden(a, b, eq, er);
      k = 0; seen = 1'b0;
      while (!seen && k < 20) begin
        @(negedge clk);
        k++;
        seen = (done === 1'b1);
      end
      check($sformatf("sweep_done %0d/%0d", a, b), 32'(seen), 32'd1);
      check($sformatf("sweep_gap %0d/%0d", a, b), 32'(k),
            32'((i == 0) ? latency(b) + 1 : latency(b)));
      check($sformatf("sweep_q %0d/%0d", a, b), 32'(quotient), 32'(eq));
      check($sformatf("sweep_r %0d/%0d", a, b), 32'(remainder), 32'(er));
`ifdef SEQ_DIV_DBZ_EN
      check($sformatf("sweep_dbz %0d/%0d", a, b), 32'(dbz), 32'(b == 0));
`endif
      if (i < (1 << (DVD_W + DVS_W)) - 1) begin
        dividend = DVD_W'((i + 1) >> DVS_W);
        divisor  = DVS_W'((i + 1) & ((1 << DVS_W) - 1));
      end else start = 1'b0;
    end
    #2;
    check("sweep_done_count", 32'(done_cnt - c0), 32'(1 << (DVD_W + DVS_W)));
    @(negedge clk); @(negedge clk);
    check("sweep_idle_busy", 32'(busy), 32'd0);

    // Random operations, some with RUN-time disturbance
    for (int n = 0; n < 24; n++) begin
      run_op(int'($urandom_range((1 << DVD_W) - 1, 0)),
             int'($urandom_range((1 << DVS_W) - 1, 0)),
             1'($urandom_range(1, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
